// File: rtl/sensor_logger.sv
// Sample logger: valid/ready writes into a 16-entry circular buffer; drains in-order bursts at threshold/flush.
// Drain: RD->CAP->OUT per word (3 cycles at m_ready=1); input stalls (s_ready=0) while draining or full.
module sensor_logger #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int THRESHOLD  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   THR_C   = (ADDR_WIDTH + 1)'(THRESHOLD);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE_C   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PINC_C  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RD, CAP, OUT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   burst_left_q, burst_left_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic drain_req;
  logic accept;
  logic out_hs;

  always_comb begin
    drain_req = (count_q >= THR_C) | (flush_pend_q & (count_q != '0));
    // Gated by rst so nothing is written while reset is held.
    s_ready   = ~rst & (state_q == IDLE) & ~drain_req & (count_q < DEPTH_C);
    accept    = s_valid & s_ready;
    m_valid   = (state_q == OUT);
    out_hs    = m_valid & m_ready;
    m_last    = m_valid & (burst_left_q == ONE_C);
    m_data    = m_data_q;
    count     = count_q;
    mem_write = accept;
    mem_read  = (state_q == RD);
    mem_addr  = (state_q == RD) ? rd_ptr_q : wr_ptr_q;
    mem_wdata = s_data;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    burst_left_d = burst_left_q;
    flush_pend_d = flush_pend_q;
    m_data_d     = m_data_q;
    case (state_q)
      IDLE: begin
        if (drain_req) begin
          state_d      = RD;
          burst_left_d = count_q;
          flush_pend_d = 1'b0;
        end else if (count_q == '0) begin
          flush_pend_d = 1'b0;
        end
        if (accept) begin
          wr_ptr_d = wr_ptr_q + PINC_C;
          count_d  = count_q + ONE_C;
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        state_d  = OUT;
        m_data_d = mem_rdata;
      end
      OUT: begin
        if (out_hs) begin
          rd_ptr_d     = rd_ptr_q + PINC_C;
          count_d      = count_q - ONE_C;
          burst_left_d = burst_left_q - ONE_C;
          state_d      = (burst_left_q > ONE_C) ? RD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request always survives; it is retired by a later drain or an empty idle.
    if (flush) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      burst_left_q <= '0;
      flush_pend_q <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      burst_left_q <= burst_left_d;
      flush_pend_q <= flush_pend_d;
      m_data_q     <= m_data_d;
    end
  end

endmodule

// File: tb/tb_sensor_logger.sv
// Directed bench for sensor_logger (THRESHOLD=4) with a 1-cycle-latency 16x8 memory model.
module tb_sensor_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       flush;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_ready;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_rdata = 8'h00;
  logic [4:0] count;

  always #5 clk = ~clk;

  sensor_logger #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .THRESHOLD(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .flush(flush),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata),
    .count(count)
  );

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  logic [8:0]  outq[$];
  logic [11:0] wrq[$];
  logic [3:0]  rdq[$];
  int          overlap = 0;

  always @(negedge clk) begin
    if (m_valid && m_ready) outq.push_back({m_last, m_data});
    if (mem_write) wrq.push_back({mem_addr, mem_wdata});
    if (mem_read) rdq.push_back(mem_addr);
    if (mem_read && mem_write) overlap++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    int c = 0;
    while (outq.size() < n && c < 300) begin
      tick();
      c++;
    end
    if (outq.size() < n) chk("timeout_out", 32'(outq.size()), 32'(n));
  endtask

  task automatic wait_vld();
    int c = 0;
    while (!m_valid && c < 50) begin
      tick();
      c++;
    end
    if (!m_valid) chk("timeout_vld", 32'(m_valid), 32'd1);
  endtask

  task automatic send(input logic [7:0] d);
    int c = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && c < 300) begin
      tick();
      c++;
    end
    if (!s_ready) chk("timeout_in", 32'(s_ready), 32'd1);
    tick();
  endtask

  task automatic check_burst(input string tag, input int n, input logic [7:0] first);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      e = outq[i];
      chk({tag, "_data"}, 32'(e[7:0]), 32'(8'(first + 8'(i))));
      chk({tag, "_last"}, 32'(e[8]), 32'(i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int c;
    logic done;
    logic [8:0]  o;
    logic [11:0] w;

    rst = 1'b1; s_valid = 1'b1; s_data = 8'h5A; flush = 1'b0; m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wdata_pass", 32'(mem_wdata), 32'h5A);
    s_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(s_ready), 1);

    // back-to-back writes, drain latency, 4-word burst
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h11 + 8'(i));
      #1;
      chk("t1_rdy", 32'(s_ready), 1);
      chk("t1_we", 32'(mem_write), 1);
      chk("t1_addr", 32'(mem_addr), 32'(i));
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("t1_rdy_drop", 32'(s_ready), 0);
    chk("t1_count4", 32'(count), 4);
    chk("t1_no_rd_yet", 32'(mem_read), 0);
    tick();
    chk("t1_rd", 32'(mem_read), 1);
    chk("t1_rd_addr", 32'(mem_addr), 0);
    tick();
    chk("t1_cap_novld", 32'(m_valid), 0);
    tick();
    chk("t1_vld", 32'(m_valid), 1);
    chk("t1_first", 32'(m_data), 32'h11);
    wait_n(4);
    check_burst("t1", 4, 8'h11);
    chk("t1_count0", 32'(count), 0);
    outq.delete();

    // backpressure on second word
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h11 + 8'(i)));
    s_valid = 1'b0;
    wait_vld();
    chk("t2_w1", 32'(m_data), 32'h11);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    wait_vld();
    chk("t2_w2", 32'(m_data), 32'h12);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_hold_vld", 32'(m_valid), 1);
      chk("t2_hold_dat", 32'(m_data), 32'h12);
      chk("t2_hold_cnt", 32'(count), 3);
      chk("t2_hold_last", 32'(m_last), 0);
    end
    m_ready = 1'b1;
    wait_n(4);
    check_burst("t2", 4, 8'h11);
    outq.delete();

    // flush below threshold, then empty flush
    send(8'hA0);
    send(8'hA1);
    s_valid = 1'b0;
    repeat (5) tick();
    chk("t3_no_drain", 32'(outq.size()), 0);
    chk("t3_count2", 32'(count), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_n(2);
    check_burst("t3", 2, 8'hA0);
    outq.delete();
    tick();
    chk("t3_count0", 32'(count), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (20) tick();
    chk("t3_empty_flush", 32'(outq.size()), 0);
    send(8'h55);
    s_valid = 1'b0;
    repeat (10) tick();
    chk("t3_pend_clear_cnt", 32'(count), 1);
    chk("t3_pend_clear_out", 32'(outq.size()), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_n(1);
    check_burst("t3b", 1, 8'h55);
    outq.delete();

    // 20 samples from a clean reset: pointer wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    outq.delete(); wrq.delete(); rdq.delete();
    for (int i = 0; i < 20; i++) send(8'(i));
    s_valid = 1'b0;
    wait_n(20);
    for (int i = 0; i < 20; i++) begin
      o = outq[i];
      chk("t4_data", 32'(o[7:0]), 32'(i));
      chk("t4_last", 32'(o[8]), 32'((i % 4) == 3));
    end
    chk("t4_nwr", 32'(wrq.size()), 20);
    w = wrq[15];
    chk("t4_addr15", 32'(w[11:8]), 15);
    w = wrq[16];
    chk("t4_wrap_addr", 32'(w[11:8]), 0);
    chk("t4_wrap_data", 32'(w[7:0]), 32'h10);
    chk("t4_nrd", 32'(rdq.size()), 20);
    for (int i = 16; i < 20; i++) chk("t4_b5_addr", 32'(rdq[i]), 32'(i - 16));
    tick();
    chk("t4_count0", 32'(count), 0);
    outq.delete();

    // s_valid held through a drain
    for (int i = 0; i < 4; i++) send(8'(8'h30 + 8'(i)));
    s_data = 8'h40;
    #1;
    bad = 0; done = 1'b0; c = 0;
    while (!done && c < 60) begin
      if (s_ready || mem_write) bad++;
      if (m_valid && m_ready && m_last) done = 1'b1;
      tick();
      c++;
    end
    chk("t5_stall", 32'(bad), 0);
    chk("t5_done", 32'(done), 1);
    chk("t5_rdy", 32'(s_ready), 1);
    chk("t5_we", 32'(mem_write), 1);
    chk("t5_addr", 32'(mem_addr), 8);
    tick();
    s_valid = 1'b0;
    #1;
    chk("t5_count1", 32'(count), 1);
    check_burst("t5", 4, 8'h30);
    outq.delete();

    // reset while presenting a word
    m_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_vld();
    chk("t6_in_out", 32'(m_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_vld", 32'(m_valid), 0);
    chk("t6_rst_cnt", 32'(count), 0);
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("t6_rdy", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data = 8'h77;
    #1;
    chk("t6_we", 32'(mem_write), 1);
    chk("t6_addr", 32'(mem_addr), 0);
    tick();
    s_valid = 1'b0;
    repeat (10) tick();
    chk("t6_count1", 32'(count), 1);
    chk("t6_no_out", 32'(outq.size()), 0);

    chk("rw_overlap", 32'(overlap), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sensor_logger.md
# sensor_logger

Upstream write/drain controller for the node's 16 x 8 sample memory. Accepts sensor samples on a valid/ready stream and stores them in the single-port memory as a circular buffer. When a threshold fill level is reached, or on a flush request, it reads the stored samples back in order and streams them as a burst to the radio framer, marking the final word. It owns every memory control port; the memory has no other master.

## Interface

Parameters:

- DATA_WIDTH, 8, sample and memory word width
- ADDR_WIDTH, 4, memory address width; DEPTH = 2**ADDR_WIDTH
- THRESHOLD, 8, fill level that triggers a drain; legal range 1..DEPTH

Ports:

- clk  in  1  rising-edge clock, shared with the memory
- rst  in  1  asynchronous, active-high reset
- s_valid  in  1  sample valid
- s_data  in  DATA_WIDTH  sample
- s_ready  out  1  sample accepted when s_valid & s_ready at the clock edge
- flush  in  1  single-cycle request to drain all stored samples
- m_valid  out  1  output word valid
- m_data  out  DATA_WIDTH  output word
- m_last  out  1  final word of the current burst
- m_ready  in  1  consumer accepts the word when m_valid & m_ready at the clock edge
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_write  out  1  memory write strobe
- mem_read  out  1  memory read strobe
- mem_rdata  in  DATA_WIDTH  memory read data
- count  out  ADDR_WIDTH+1  number of stored, undrained samples

## Operation

- Registers:
  - wr_ptr and rd_ptr, ADDR_WIDTH bits each; both wrap modulo DEPTH with no special case.
  - count, 0..DEPTH.
  - burst_left, ADDR_WIDTH+1 bits.
  - flush_pend.
  - state.
- FSM states:
  - IDLE: accept samples.
  - RD: mem_read=1, mem_addr=rd_ptr.
  - CAP: register mem_rdata into m_data.
  - OUT: hold m_valid until m_ready.
- drain_req = (count >= THRESHOLD) | (flush_pend & count != 0).
- IDLE transitions:
  - If drain_req: go to RD, set burst_left = count, clear flush_pend.
  - Otherwise stay in IDLE.
- Remaining transitions:
  - RD always goes to CAP.
  - CAP always goes to OUT.
  - OUT on m_valid & m_ready:
    - rd_ptr += 1, count -= 1, burst_left -= 1.
    - Go to RD if burst_left was > 1; otherwise go to IDLE.
- Writes:
  - s_ready = (state==IDLE) & !drain_req & (count < DEPTH).
  - mem_write = s_valid & s_ready, with mem_addr = wr_ptr and mem_wdata = s_data. These are combinational, so the memory writes on the accepting edge.
  - On accept: wr_ptr += 1, count += 1.
- mem_addr mux:
  - rd_ptr in RD.
  - wr_ptr otherwise.
  - mem_read = 0 outside RD; mem_write = 0 outside IDLE.
- The memory is single-port, so mem_read and mem_write are never asserted in the same cycle.
- Flush handling:
  - flush sets flush_pend in any state.
  - flush_pend clears on drain start, or in IDLE when count==0 (an empty flush is a no-op).
- m_last = m_valid & (burst_left == 1).
- Samples arriving during a drain are stalled (s_ready=0), never dropped.

## Timing

- Reset values:
  - state=IDLE; wr_ptr, rd_ptr, count, burst_left = 0; flush_pend=0.
  - m_valid=0, m_last=0, m_data=0.
  - mem_write=0, mem_read=0, mem_addr=0, mem_wdata = s_data (combinational pass-through).
  - s_ready=1 once rst deasserts.
- Reset mid-burst aborts immediately. All stored samples are discarded logically; memory contents are not cleared.
- Memory read latency is 1: mem_rdata is valid the cycle after the RD cycle.
- Drain latency:
  - The edge that makes count reach THRESHOLD moves the FSM to RD on the next edge.
  - m_valid rises 2 cycles after entry to RD.
- Per-word cost is 3 cycles (RD, CAP, OUT) with m_ready held high. m_data and m_last stay stable while m_valid & !m_ready.
- Write throughput is 1 sample/cycle in IDLE.
- THRESHOLD=DEPTH: drain starts at count=DEPTH, so s_ready is low while full.

## Test plan

- THRESHOLD=4, write 0x11,0x12,0x13,0x14 back-to-back -> mem_write on 4 consecutive edges at addresses 0..3. s_ready drops the cycle after the 4th accept. Burst 0x11..0x14 follows, with m_last only on 0x14. count returns to 0.
- Same burst with m_ready low for 5 cycles on the 2nd word -> m_data=0x12 and m_valid held stable. No pointer movement. Order is intact afterwards.
- Write 0xA0,0xA1, then pulse flush -> 2-word burst, m_last on 0xA1. A flush with count=0 produces no m_valid and leaves flush_pend=0.
- 20 samples 0x00..0x13 with THRESHOLD=4 -> wr_ptr wraps 15→0. The 5th burst reads addresses 0..3 and outputs 0x10..0x13.
- s_valid held high during a drain -> s_ready=0 and mem_write=0 throughout the drain. The sample is accepted the first IDLE cycle afterwards, and mem_read and mem_write are never both high.
- Assert rst while in OUT of a burst -> m_valid=0 and count=0 immediately. After release, s_ready=1 and the next sample is written to address 0.
